// File: rtl/vedic_mac_pkg.sv
// Shared types and sizing for the vedic_mac_acc frame accumulator.
// Optional saturation is selected by the VEDIC_MAC_ACC_SAT_EN macro in vedic_mac_acc.sv.
package vedic_mac_pkg;

   localparam int PROD_W    = 128;
   localparam int ACC_W_DEF = 136;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/vedic_acc_adder.sv
// Combinational W-bit adder with carry-out used by the accumulator.
module vedic_acc_adder #(
   parameter int W = 136
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/vedic_mac_acc.sv
// Frame-based accumulator of 129-bit multiplier products with sticky overflow.
// Define VEDIC_MAC_ACC_SAT_EN to saturate on overflow instead of wrapping.
module vedic_mac_acc
   import vedic_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_cout,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res,
   output logic              res_ovf,
   output logic              busy
);

   state_e             state;
   logic [ACC_W-1:0]   acc;
   logic [LEN_W-1:0]   count;
   logic [LEN_W-1:0]   len_q;
   logic               ovf;

   logic [ACC_W-1:0]   addend;
   logic [ACC_W-1:0]   sum;
   logic               carry;
   logic [LEN_W-1:0]   count_next;

   // The product carry-out sits at bit PROD_W of the addend; ACC_W must be at least PROD_W+1.
   always_comb begin
      addend             = '0;
      addend[PROD_W:0]   = {prod_cout, prod};
   end

   assign count_next = count + LEN_W'(1);

   vedic_acc_adder #(
      .W (ACC_W)
   ) u_adder (
      .a    (acc),
      .b    (addend),
      .sum  (sum),
      .cout (carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         len_q <= '0;
         ovf   <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  count <= '0;
                  ovf   <= 1'b0;
                  len_q <= len;
                  state <= (len == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (prod_valid) begin
                  // Once saturated, any further nonzero add carries again, so all-ones is held.
`ifdef VEDIC_MAC_ACC_SAT_EN
                  acc <= carry ? '1 : sum;
`else
                  acc <= sum;
`endif
                  ovf   <= ovf | carry;
                  count <= count_next;
                  if (count_next == len_q) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign prod_ready = (state == ACCUM);
   assign res_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign res        = acc;
   assign res_ovf    = ovf;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Directed self-checking bench for vedic_mac_acc (default and ACC_W=129 instances).
// Saturation expectations follow the VEDIC_MAC_ACC_SAT_EN macro.
module tb_vedic_mac_acc;

   logic         clk;
   logic         rst_n;

   logic         start;
   logic [7:0]   len;
   logic         abort;
   logic         prod_valid;
   logic         prod_ready;
   logic [127:0] prod;
   logic         prod_cout;
   logic         res_valid;
   logic         res_ready;
   logic [135:0] res;
   logic         res_ovf;
   logic         busy;

   logic         w_start;
   logic [7:0]   w_len;
   logic         w_abort;
   logic         w_prod_valid;
   logic         w_prod_ready;
   logic [127:0] w_prod;
   logic         w_prod_cout;
   logic         w_res_valid;
   logic         w_res_ready;
   logic [128:0] w_res;
   logic         w_res_ovf;
   logic         w_busy;

   int           checks;
   int           passed;
   int           failed;
   int           xfers;
   logic [135:0] expv;

   vedic_mac_acc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .abort      (abort),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod       (prod),
      .prod_cout  (prod_cout),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res        (res),
      .res_ovf    (res_ovf),
      .busy       (busy)
   );

   vedic_mac_acc #(
      .ACC_W (129),
      .LEN_W (8)
   ) dut_narrow (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (w_start),
      .len        (w_len),
      .abort      (w_abort),
      .prod_valid (w_prod_valid),
      .prod_ready (w_prod_ready),
      .prod       (w_prod),
      .prod_cout  (w_prod_cout),
      .res_valid  (w_res_valid),
      .res_ready  (w_res_ready),
      .res        (w_res),
      .res_ovf    (w_res_ovf),
      .busy       (w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives the default instance's inputs, then advances one clock edge.
   task automatic applyStimulus(input logic s, input logic [7:0] l, input logic pv,
                                input logic [127:0] p, input logic pc, input logic rr);
      start      = s;
      len        = l;
      prod_valid = pv;
      prod       = p;
      prod_cout  = pc;
      res_ready  = rr;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0; passed = 0; failed = 0; xfers = 0;
      rst_n = 1'b0;
      start = 0; len = 0; abort = 0; prod_valid = 0; prod = '0; prod_cout = 0; res_ready = 0;
      w_start = 0; w_len = 0; w_abort = 0; w_prod_valid = 0; w_prod = '0; w_prod_cout = 0;
      w_res_ready = 0;

      #12;
      checkOutput("reset_res", res, 136'd0);
      checkOutput("reset_flags", {132'd0, prod_ready, res_valid, busy, res_ovf}, 136'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("idle_after_reset", {133'd0, prod_ready, res_valid, busy}, 136'd0);

      $display("[TB] frame len=3 products 5,7,9");
      applyStimulus(1, 8'd3, 0, 128'd0, 0, 0);
      checkOutput("accum_ready", {134'd0, prod_ready, busy}, 136'd3);
      applyStimulus(0, 8'd0, 1, 128'd5, 0, 0);
      applyStimulus(0, 8'd0, 1, 128'd7, 0, 0);
      checkOutput("no_valid_before_last", {135'd0, res_valid}, 136'd0);
      applyStimulus(0, 8'd0, 1, 128'd9, 0, 0);
      checkOutput("sum3_valid", {135'd0, res_valid}, 136'd1);
      checkOutput("sum3_res", res, 136'd21);
      checkOutput("sum3_ovf", {135'd0, res_ovf}, 136'd0);
      checkOutput("sum3_not_ready", {135'd0, prod_ready}, 136'd0);
      applyStimulus(0, 8'd0, 0, 128'd0, 0, 1);
      checkOutput("sum3_back_idle", {135'd0, busy}, 136'd0);

      $display("[TB] frame len=1 max product with carry");
      applyStimulus(1, 8'd1, 0, 128'd0, 0, 0);
      applyStimulus(0, 8'd0, 1, {128{1'b1}}, 1, 0);
      expv = '0;
      expv[128:0] = {129{1'b1}};
      checkOutput("max_res", res, expv);
      checkOutput("max_ovf", {135'd0, res_ovf}, 136'd0);
      applyStimulus(0, 8'd0, 0, 128'd0, 0, 1);

      $display("[TB] ACC_W=129 overflow frame");
      res_ready = 0;
      w_start = 1; w_len = 8'd2;
      tick();
      w_start = 0; w_len = 0;
      w_prod_valid = 1; w_prod = '0; w_prod_cout = 1;
      tick();
      tick();
      w_prod_valid = 0; w_prod_cout = 0;
      checkOutput("narrow_valid", {135'd0, w_res_valid}, 136'd1);
      expv = '0;
`ifdef VEDIC_MAC_ACC_SAT_EN
      expv[128:0] = {129{1'b1}};
`endif
      checkOutput("narrow_res", {7'd0, w_res}, expv);
      checkOutput("narrow_ovf", {135'd0, w_res_ovf}, 136'd1);
      w_res_ready = 1;
      tick();
      w_res_ready = 0;
      checkOutput("narrow_idle", {135'd0, w_busy}, 136'd0);

      $display("[TB] len=4 with toggling prod_valid and delayed res_ready");
      applyStimulus(1, 8'd4, 0, 128'd0, 0, 0);
      xfers = 0;
      for (int i = 0; i < 10; i++) begin
         start = 0; len = 0; res_ready = 0; prod_cout = 0; prod = 128'd1;
         prod_valid = ((i % 2) == 0);
         if (prod_valid && prod_ready) xfers++;
         tick();
      end
      prod_valid = 0;
      checkOutput("toggle_xfers", 136'(xfers), 136'd4);
      checkOutput("toggle_res", res, 136'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_res", res, 136'd4);
         checkOutput("hold_valid", {135'd0, res_valid}, 136'd1);
      end
      applyStimulus(0, 8'd0, 0, 128'd0, 0, 1);
      checkOutput("toggle_released", {134'd0, res_valid, busy}, 136'd0);

      $display("[TB] abort mid-frame then fresh frame");
      applyStimulus(1, 8'd4, 0, 128'd0, 0, 0);
      applyStimulus(0, 8'd0, 1, 128'd3, 0, 0);
      applyStimulus(0, 8'd0, 1, 128'd3, 0, 0);
      prod_valid = 0;
      abort = 1;
      tick();
      abort = 0;
      checkOutput("abort_res", res, 136'd0);
      checkOutput("abort_flags", {134'd0, res_valid, busy}, 136'd0);
      applyStimulus(1, 8'd1, 0, 128'd0, 0, 0);
      applyStimulus(0, 8'd0, 1, 128'd10, 0, 0);
      checkOutput("post_abort_res", res, 136'd10);
      checkOutput("post_abort_valid", {134'd0, res_valid, res_ovf}, 136'd2);
      applyStimulus(0, 8'd0, 0, 128'd0, 0, 1);

      $display("[TB] len=0, start in DONE, reset mid-frame");
      applyStimulus(1, 8'd0, 0, 128'd0, 0, 0);
      checkOutput("len0_valid", {135'd0, res_valid}, 136'd1);
      checkOutput("len0_res", res, 136'd0);
      applyStimulus(1, 8'd5, 0, 128'd0, 0, 0);
      checkOutput("start_in_done", {134'd0, res_valid, prod_ready}, 136'd2);
      applyStimulus(0, 8'd0, 0, 128'd0, 0, 1);
      applyStimulus(1, 8'd3, 0, 128'd0, 0, 0);
      applyStimulus(0, 8'd0, 1, 128'd7, 0, 0);
      checkOutput("pre_reset_res", res, 136'd7);
      prod_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_res", res, 136'd0);
      checkOutput("mid_reset_flags", {132'd0, prod_ready, res_valid, busy, res_ovf}, 136'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("after_reset_quiet", {133'd0, prod_ready, res_valid, busy}, 136'd0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
